// File: rtl/load_store_unit.sv
// MEM-stage load/store controller: decodes RV32I funct3 into memory size codes,
// splits misaligned accesses into byte accesses, and registers load results for WB.
module load_store_unit #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_write,
    output logic [1:0]  mem_data,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_err
);
    typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        load;
    } req_t;

    state_t      state, state_nxt;
    req_t        cap;
    logic [1:0]  idx;
    logic [31:0] acc, acc_nxt, split_ext, aligned_ext;
    logic        is_load, is_store, legal, misal, start_split, last_byte;
    logic [1:0]  sz, last_idx;

    assign is_load  = req_valid & req_load & ~req_store;
    assign is_store = req_valid & req_store & ~req_load;
    assign sz       = req_funct3[1:0];

    always_comb begin
        legal = 1'b0;
        if (is_load)
            legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (is_store)
            legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    end

    assign misal       = (sz == 2'b01 && req_addr[0]) || (sz == 2'b10 && req_addr[1:0] != 2'b00);
    assign start_split = SPLIT_MISALIGNED && legal && misal;
    assign last_idx    = (cap.funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
    assign last_byte   = (state == SPLIT) && (idx == last_idx);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_split) state_nxt = SPLIT;
            SPLIT:   if (last_byte)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-side outputs; everything is quiet during reset so a split store is cut short
    always_comb begin
        mem_address = req_addr;
        mem_data_in = req_wdata;
        mem_write   = 2'b00;
        mem_data    = 2'b10;
        stall       = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (legal && !misal) begin
                        if (is_store) mem_write = sz + 2'd1;
                        else          mem_data  = sz;
                    end else if (start_split) begin
                        if (is_store) mem_write = 2'b01;
                        else          mem_data  = 2'b00;
                        stall = 1'b1;
                    end
                end
                SPLIT: begin
                    mem_address = cap.addr + {30'd0, idx};
                    mem_data_in = cap.wdata >> {idx, 3'b000};
                    if (cap.load) mem_data  = 2'b00;
                    else          mem_write = 2'b01;
                    stall = !last_byte;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        acc_nxt = acc;
        acc_nxt[{idx, 3'b000} +: 8] = mem_rdata[7:0];
    end

    always_comb begin
        case (cap.funct3)
            3'b001:  split_ext = {{16{acc_nxt[15]}}, acc_nxt[15:0]};
            3'b101:  split_ext = {16'd0, acc_nxt[15:0]};
            default: split_ext = acc_nxt;
        endcase
    end

    // Memory already sign-extends B/H; only the unsigned forms need zero-extension here
    always_comb begin
        case (req_funct3)
            3'b100:  aligned_ext = {24'd0, mem_rdata[7:0]};
            3'b101:  aligned_ext = {16'd0, mem_rdata[15:0]};
            default: aligned_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'd0;
            misalign_err <= 1'b0;
            idx          <= 2'd0;
            acc          <= 32'd0;
            cap          <= '0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            if (state == IDLE) begin
                if (is_load && !legal) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= req_rd;
                    wb_data  <= 32'd0;
                end else if (legal && !misal && is_load) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= req_rd;
                    wb_data  <= aligned_ext;
                end else if (start_split) begin
                    cap <= '{addr: req_addr, wdata: req_wdata, funct3: req_funct3,
                             rd: req_rd, load: is_load};
                    acc <= {24'd0, mem_rdata[7:0]};
                    idx <= 2'd1;
                end else if (legal && misal) begin
                    misalign_err <= 1'b1;
                end
            end else begin
                acc <= acc_nxt;
                idx <= idx + 2'd1;
                if (last_byte) begin
                    idx <= 2'd0;
                    if (cap.load) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= cap.rd;
                        wb_data  <= split_ext;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table for aligned accesses plus
// hand sequences for split, reset-during-split and the no-split variant.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;

    logic        stall, wb_valid, misalign_err;
    logic [31:0] mem_address, mem_data_in, mem_rdata, wb_data;
    logic [1:0]  mem_write, mem_data;
    logic [4:0]  wb_rd;

    logic        stall_0, wb_valid_0, misalign_err_0;
    logic [31:0] mem_address_0, mem_data_in_0, mem_rdata_0, wb_data_0;
    logic [1:0]  mem_write_0, mem_data_0;
    logic [4:0]  wb_rd_0;

    logic [7:0]  mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_load(req_load),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .stall(stall),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write),
        .mem_data(mem_data), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .misalign_err(misalign_err));

    load_store_unit #(.SPLIT_MISALIGNED(1'b0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_load(req_load),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .stall(stall_0),
        .mem_address(mem_address_0), .mem_data_in(mem_data_in_0), .mem_write(mem_write_0),
        .mem_data(mem_data_0), .mem_rdata(mem_rdata_0), .wb_valid(wb_valid_0),
        .wb_rd(wb_rd_0), .wb_data(wb_data_0), .misalign_err(misalign_err_0));

    // Byte memory model, little-endian, sign-extending reads (only dut writes it)
    logic [7:0] a, a0;
    assign a  = mem_address[7:0];
    assign a0 = mem_address_0[7:0];
    always_comb begin
        case (mem_data)
            2'b00:   mem_rdata = {{24{mem[a][7]}}, mem[a]};
            2'b01:   mem_rdata = {{16{mem[a+8'd1][7]}}, mem[a+8'd1], mem[a]};
            default: mem_rdata = {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
        endcase
        case (mem_data_0)
            2'b00:   mem_rdata_0 = {{24{mem[a0][7]}}, mem[a0]};
            2'b01:   mem_rdata_0 = {{16{mem[a0+8'd1][7]}}, mem[a0+8'd1], mem[a0]};
            default: mem_rdata_0 = {mem[a0+8'd3], mem[a0+8'd2], mem[a0+8'd1], mem[a0]};
        endcase
    end

    always @(posedge clk) begin
        case (mem_write)
            2'b01: mem[a] <= mem_data_in[7:0];
            2'b10: begin mem[a] <= mem_data_in[7:0]; mem[a+8'd1] <= mem_data_in[15:8]; end
            2'b11: begin
                mem[a] <= mem_data_in[7:0];        mem[a+8'd1] <= mem_data_in[15:8];
                mem[a+8'd2] <= mem_data_in[23:16]; mem[a+8'd3] <= mem_data_in[31:24];
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [4:0] rd);
        req_valid  = ld | st;
        req_load   = ld;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = ad;
        req_wdata  = wd;
        req_rd     = rd;
    endtask

    typedef struct {
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        logic [4:0]  rd;
        logic [1:0]  mw;
        logic        wbv;
        logic [31:0] wbd;
    } vec_t;

    vec_t vecs [14];
    logic [31:0] sw_val;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        mem[8'h20] <= 8'hF0;
        mem[8'h22] <= 8'h01; mem[8'h23] <= 8'h80;
        mem[8'h43] <= 8'h7F; mem[8'h44] <= 8'h80;
        for (int i = 8'h51; i <= 8'h54; i++) mem[i] <= 8'hAA;

        //          ld    st    f3      addr    wdata          rd    mw     wbv   wbd
        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 2'b11, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        5'd5, 2'b00, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h20, 32'h0,        5'd6, 2'b00, 1'b1, 32'hFFFFFFF0};
        vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h20, 32'h0,        5'd7, 2'b00, 1'b1, 32'h000000F0};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h22, 32'h0,        5'd8, 2'b00, 1'b1, 32'hFFFF8001};
        vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h22, 32'h0,        5'd9, 2'b00, 1'b1, 32'h00008001};
        vecs[6]  = '{1'b1, 1'b0, 3'b011, 32'h10, 32'h0,        5'd10, 2'b00, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 3'b100, 32'h10, 32'h12345678, 5'd0, 2'b00, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h70, 32'h0000005A, 5'd0, 2'b01, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 3'b100, 32'h70, 32'h0,        5'd11, 2'b00, 1'b1, 32'h0000005A};
        vecs[10] = '{1'b0, 1'b1, 3'b001, 32'h72, 32'h00001234, 5'd0, 2'b10, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h70, 32'h0,        5'd12, 2'b00, 1'b1, 32'h1234005A};
        vecs[12] = '{1'b0, 1'b0, 3'b010, 32'h10, 32'h0,        5'd13, 2'b00, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        5'd0,  2'b00, 1'b1, 32'hDEADBEEF};

        // Reset with a misaligned store presented: nothing may reach memory
        reset = 1'b1;
        drive(1'b0, 1'b1, 3'b010, 32'h31, 32'hCAFEF00D, 5'd0);
        @(negedge clk); #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_mem_write", {30'd0, mem_write}, 32'd0);
        @(posedge clk); #1;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misalign_err", {31'd0, misalign_err_0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        @(posedge clk);

        // Aligned single-cycle table
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rd);
            #1;
            chk($sformatf("v%0d_mem_write", i), {30'd0, mem_write}, {30'd0, vecs[i].mw});
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_wb_valid", i), {31'd0, wb_valid}, {31'd0, vecs[i].wbv});
            if (vecs[i].wbv) begin
                chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].wbd);
                chk($sformatf("v%0d_wb_rd", i), {27'd0, wb_rd}, {27'd0, vecs[i].rd});
            end
        end

        // Misaligned SW 0x11223344 @0x31: four byte writes, stall for three
        sw_val = 32'h11223344;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) drive(1'b0, 1'b1, 3'b010, 32'h31, sw_val, 5'd0);
            #1;
            chk($sformatf("sw_addr%0d", i), mem_address, 32'h31 + i);
            chk($sformatf("sw_mw%0d", i), {30'd0, mem_write}, 32'd1);
            chk($sformatf("sw_byte%0d", i), {24'd0, mem_data_in[7:0]}, {24'd0, sw_val[8*i +: 8]});
            chk($sformatf("sw_stall%0d", i), {31'd0, stall}, {31'd0, i < 3});
            if (i == 0) chk("nosplit_sw_mw", {30'd0, mem_write_0}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("sw_wbv%0d", i), {31'd0, wb_valid}, 32'd0);
        end
        chk("sw_mem31", {mem[8'h34], mem[8'h33], mem[8'h32], mem[8'h31]}, 32'h11223344);

        // Misaligned LW @0x31 reassembles the word after four cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) drive(1'b1, 1'b0, 3'b010, 32'h31, 32'h0, 5'd3);
            #1;
            chk($sformatf("lw_stall%0d", i), {31'd0, stall}, {31'd0, i < 3});
            chk($sformatf("lw_md%0d", i), {30'd0, mem_data}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("lw_wbv%0d", i), {31'd0, wb_valid}, {31'd0, i == 3});
        end
        chk("lw_wb_data", wb_data, 32'h11223344);
        chk("lw_wb_rd", {27'd0, wb_rd}, 32'd3);

        // Misaligned LH / LHU @0x43: bytes 7F, 80
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                if (i == 0) drive(1'b1, 1'b0, (j == 0) ? 3'b001 : 3'b101, 32'h43, 32'h0, 5'd4);
                #1;
                chk($sformatf("lh%0d_stall%0d", j, i), {31'd0, stall}, {31'd0, i == 0});
                chk($sformatf("lh%0d_addr%0d", j, i), mem_address, 32'h43 + i);
                @(posedge clk); #1;
            end
            chk($sformatf("lh%0d_wbv", j), {31'd0, wb_valid}, 32'd1);
            chk($sformatf("lh%0d_wb_data", j), wb_data, (j == 0) ? 32'hFFFF807F : 32'h0000807F);
        end

        // Reset in the second cycle of a split SW @0x51: only byte 0 lands
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b010, 32'h51, 32'h99887766, 5'd0);
        #1;
        chk("rs_stall0", {31'd0, stall}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rs_stall_in_reset", {31'd0, stall}, 32'd0);
        chk("rs_mw_in_reset", {30'd0, mem_write}, 32'd0);
        @(posedge clk); #1;
        chk("rs_wbv_in_reset", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        #1;
        chk("rs_stall_after", {31'd0, stall}, 32'd0);
        chk("rs_mw_after", {30'd0, mem_write}, 32'd0);
        @(posedge clk); #1;
        chk("rs_wbv_after", {31'd0, wb_valid}, 32'd0);
        chk("rs_mem51", {mem[8'h54], mem[8'h53], mem[8'h52], mem[8'h51]}, 32'hAAAAAA66);

        // No-split variant: misaligned LW / SW @0x62 are dropped with a one-cycle pulse
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            drive(j == 0, j == 1, 3'b010, 32'h62, 32'h55555555, 5'd9);
            #1;
            chk($sformatf("ns%0d_mw", j), {30'd0, mem_write_0}, 32'd0);
            chk($sformatf("ns%0d_stall", j), {31'd0, stall_0}, 32'd0);
            @(negedge clk);
            drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
            #1;
            chk($sformatf("ns%0d_err", j), {31'd0, misalign_err_0}, 32'd1);
            chk($sformatf("ns%0d_wbv", j), {31'd0, wb_valid_0}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("ns%0d_err_clr", j), {31'd0, misalign_err_0}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
